// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        RECV       = 2'd1,
        SYNC_CHECK = 2'd2
    } tdm_state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_WIDTH  = 8;

endpackage

// File: rtl/tdm_deser.sv
// MSB-first shift-in register; clear restarts the word with the incoming bit.
module tdm_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] word_q;

    // next_o is the word as it stands once this beat is shifted in
    always_comb begin
        if (clr_i) begin
            next_o = {{(WIDTH-1){1'b0}}, bit_i};
        end else begin
            next_o = {word_q[WIDTH-2:0], bit_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else if (en_i) begin
            word_q <= next_o;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer: hunts for frame sync, deserialises each slot
// into its own word register and flags framing violations.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH  = DEF_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    IN_DATA,
    input  logic                    IN_VALID,
    input  logic                    FRAME_SYNC,
    output logic [NUM_CH*WIDTH-1:0] CH_DATA,
    output logic [NUM_CH-1:0]       CH_VALID,
    output logic                    LOCKED,
    output logic                    FRAME_ERR,
    output tdm_state_e              DBG_STATE
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = $clog2(NUM_CH);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);

    tdm_state_e state_q, state_d;

    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
    logic [NUM_CH*WIDTH-1:0] ch_data_q;
    logic [NUM_CH-1:0]       ch_valid_q, ch_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    locked_q;

    logic                    accept;
    logic                    restart;
    logic                    word_done;
    logic [BW-1:0]           pos_bit;
    logic [SW-1:0]           pos_slot;
    logic [WIDTH-1:0]        word_next;

    tdm_deser #(.WIDTH(WIDTH)) u_deser (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .en_i   (accept),
        .clr_i  (restart),
        .bit_i  (IN_DATA),
        .next_o (word_next)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (IN_VALID) begin
            case (state_q)
                HUNT: begin
                    if (FRAME_SYNC) state_d = RECV;
                end
                RECV: begin
                    if (word_done && pos_slot == LAST_SLOT) state_d = SYNC_CHECK;
                end
                SYNC_CHECK: begin
                    state_d = FRAME_SYNC ? RECV : HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // A sync beat always becomes slot 0 bit 0, whatever position the counters held.
    always_comb begin
        restart     = IN_VALID && FRAME_SYNC;
        accept      = IN_VALID && (FRAME_SYNC || state_q == RECV);
        pos_bit     = restart ? '0 : bit_cnt_q;
        pos_slot    = restart ? '0 : slot_cnt_q;
        word_done   = accept && (pos_bit == LAST_BIT);
        ch_valid_d  = word_done ? (NUM_CH'(1) << pos_slot) : '0;
        frame_err_d = IN_VALID &&
                      ((state_q == RECV && FRAME_SYNC &&
                        (bit_cnt_q != '0 || slot_cnt_q != '0)) ||
                       (state_q == SYNC_CHECK && !FRAME_SYNC));
        bit_cnt_d   = bit_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        if (accept) begin
            bit_cnt_d  = word_done ? '0 : pos_bit + BW'(1);
            slot_cnt_d = word_done ? pos_slot + SW'(1) : pos_slot;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bit_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            ch_data_q   <= '0;
            ch_valid_q  <= '0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            ch_valid_q  <= ch_valid_d;
            frame_err_q <= frame_err_d;
            locked_q    <= (state_d != HUNT);
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid_d[k]) ch_data_q[k*WIDTH +: WIDTH] <= word_next;
            end
        end
    end

    assign CH_DATA   = ch_data_q;
    assign CH_VALID  = ch_valid_q;
    assign LOCKED    = locked_q;
    assign FRAME_ERR = frame_err_q;
    assign DBG_STATE = state_q;

endmodule
